cache_mem_responder: RTL and testbench
======================================

CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

Interface
REQ-001 The block SHALL have parameter NUM_BLOCKS, default 256, meaning the number of memory blocks.
REQ-002 The block SHALL have parameter BLOCK_SIZE, default 16, meaning words per block (power of two).
REQ-003 The block SHALL have parameter WORD_W, default 32, meaning bits per data word.
REQ-004 The block SHALL have parameter LATENCY, default 4, meaning wait cycles from request accept to first beat (legal range 1..15).
REQ-005 The block SHALL have parameter BLK_W, default $clog2(NUM_BLOCKS), meaning block address width.
REQ-006 One clock; reset is asynchronous and active-low: port clk, input, 1 bit, rising-edge clock; port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 req_valid  input  1  cache presents a block request.
REQ-008 req_ready  output  1  responder accepts the request this cycle.
REQ-009 req_write  input  1  1 = dirty writeback, 0 = line fill.
REQ-010 req_block  input  BLK_W  block number in memory.
REQ-011 wdata_valid / wdata_ready  input / output  1 each  writeback beat handshake.
REQ-012 wdata  input  WORD_W  writeback word; beats arrive at offsets 0..BLOCK_SIZE-1 in order.
REQ-013 rdata_valid / rdata_ready  output / input  1 each  fill beat handshake.
REQ-014 rdata  output  WORD_W  fill word, offset order 0..BLOCK_SIZE-1.
REQ-015 rdata_last  output  1  high with the final fill beat.
REQ-016 wb_done  output  1  one-cycle pulse after the last writeback beat is stored.
REQ-017 fill_cnt / wb_cnt  output  16 each  completed fills / writebacks, saturating at 16'hFFFF.

Function
REQ-018 Storage SHALL be NUM_BLOCKS x BLOCK_SIZE words of WORD_W bits, all zero at time zero.
REQ-019 FSM states SHALL be IDLE, WAIT, RD_BURST, WR_BURST, WB_ACK.
REQ-020 req_ready SHALL be high only in IDLE; the handshake completes when req_valid and req_ready are both high; req_block and req_write are latched at that edge.
REQ-021 IDLE -> WAIT on accept; WAIT holds exactly LATENCY cycles (down-counter), then -> RD_BURST if a read was latched, else WR_BURST.
REQ-022 RD_BURST: rdata_valid high; beat counter starts at 0; a beat transfers when rdata_ready is high; the counter then increments.
REQ-023 While rdata_valid is high and rdata_ready is low, rdata and rdata_last SHALL hold stable.
REQ-024 rdata_last SHALL be high only on beat BLOCK_SIZE-1; that transfer -> IDLE and increments fill_cnt.
REQ-025 WR_BURST: wdata_ready high; each transfer writes wdata to memory[block][beat]; the transfer of beat BLOCK_SIZE-1 -> WB_ACK.
REQ-026 WB_ACK SHALL last one cycle with wb_done high, increment wb_cnt, then -> IDLE.
REQ-027 wdata_ready SHALL be low outside WR_BURST; wdata_valid outside WR_BURST is ignored.
REQ-028 Requests are served strictly in order; a fill accepted after a writeback to the same block SHALL return the written data.
REQ-029 req_block >= NUM_BLOCKS SHALL be accepted; the index wraps modulo NUM_BLOCKS.
REQ-030 Minimum request-to-request spacing: fill 1+LATENCY+BLOCK_SIZE cycles, writeback 2+LATENCY+BLOCK_SIZE cycles, with no backpressure.

Reset
REQ-031 On rst_n low, the FSM SHALL go to IDLE and beat and wait counters SHALL clear; outputs are req_ready=1, rdata_valid=0, rdata_last=0, wdata_ready=0, wb_done=0, fill_cnt=0, wb_cnt=0, rdata=0.
REQ-032 Reset mid-burst SHALL abort the burst; the abort is not counted; words already written stay written; memory contents are never cleared by reset.

Structure
REQ-033 A shared package cache_pkg SHALL hold NUM_BLOCKS, BLOCK_SIZE, WORD_W, OFFSET_BITS=4, and the FSM state enum, for use by the cache and this block.
REQ-034 The storage array SHALL be one sub-module, mem_block_ram: single port, synchronous write, combinational read indexed {block, beat}.

Verification
REQ-035 Reset, then a fill of block 2 -> 16 zero words; rdata_last on beat 15; fill_cnt=1; first beat LATENCY+1 cycles after accept.
REQ-036 Writeback of block 5 with words 0x100+i, then a fill of block 5 -> wb_done pulses once; the fill returns 0x100..0x10F in order; wb_cnt=1.
REQ-037 Fill with rdata_ready toggling 1,0,0,1 -> rdata stable across the stalls; 16 beats total, no duplicates or skips.
REQ-038 req_valid held high throughout a burst -> req_ready=0 until back in IDLE; the second request is accepted exactly once.
REQ-039 rst_n asserted at writeback beat 7 of block 9, then a fill of block 9 -> words 0..6 are new, words 7..15 are old; wb_cnt=0.
REQ-040 Writeback to block 300 with NUM_BLOCKS=256 -> data lands in block 44; a fill of block 44 returns it.

Source files
------------

// File: rtl/cache_pkg.sv
//------------------------------------------------------------------------------
// Module      : cache_pkg
// Description : Shared geometry constants and responder state encoding.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cache_pkg;

   localparam int NUM_BLOCKS  = 256;
   localparam int BLOCK_SIZE  = 16;
   localparam int WORD_W      = 32;
   localparam int OFFSET_BITS = 4;
   localparam int LATENCY     = 4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT     = 3'd1,
      ST_RD_BURST = 3'd2,
      ST_WR_BURST = 3'd3,
      ST_WB_ACK   = 3'd4
   } state_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_block_ram.sv
//------------------------------------------------------------------------------
// Module      : mem_block_ram
// Description : Single-port word store, synchronous write, combinational read.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_block_ram #(
   parameter int ADDR_W = 12,
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [WORD_W-1:0] i_wdata,
   output logic [WORD_W-1:0] o_rdata
);

   import cache_pkg::*;

   localparam int DEPTH = 1 << ADDR_W;

   // Contents start at zero and are deliberately outside the reset domain.
   logic [WORD_W-1:0] r_mem [DEPTH] = '{default: '0};

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/cache_mem_responder.sv
//------------------------------------------------------------------------------
// Module      : cache_mem_responder
// Description : Backing-memory responder serving cache line fills and writebacks.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cache_mem_responder #(
   parameter int NUM_BLOCKS = cache_pkg::NUM_BLOCKS,
   parameter int BLOCK_SIZE = cache_pkg::BLOCK_SIZE,
   parameter int WORD_W     = cache_pkg::WORD_W,
   parameter int LATENCY    = cache_pkg::LATENCY,
   parameter int BLK_W      = $clog2(NUM_BLOCKS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [BLK_W-1:0]  req_block,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   input  logic [WORD_W-1:0] wdata,
   output logic              rdata_valid,
   input  logic              rdata_ready,
   output logic [WORD_W-1:0] rdata,
   output logic              rdata_last,
   output logic              wb_done,
   output logic [15:0]       fill_cnt,
   output logic [15:0]       wb_cnt
);

   import cache_pkg::*;

   localparam int IDX_W  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
   localparam int OFF_W  = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam int ADDR_W = IDX_W + OFF_W;

   localparam logic [OFF_W-1:0] c_LAST_BEAT = OFF_W'(BLOCK_SIZE - 1);
   localparam logic [3:0]       c_WAIT_LOAD = 4'(LATENCY - 1);

   state_t             r_state;
   state_t             w_next;
   logic [IDX_W-1:0]   r_blk;
   logic               r_write;
   logic [OFF_W-1:0]   r_beat;
   logic [3:0]         r_wait;
   logic [15:0]        r_fill_cnt;
   logic [15:0]        r_wb_cnt;

   logic [IDX_W-1:0]   w_blk_idx;
   logic               w_last_beat;
   logic               w_ram_we;
   logic [ADDR_W-1:0]  w_ram_addr;
   logic [WORD_W-1:0]  w_ram_rdata;

   // Out-of-range block numbers fold back into the array.
   assign w_blk_idx   = IDX_W'(32'(req_block) % 32'(NUM_BLOCKS));
   assign w_last_beat = (r_beat == c_LAST_BEAT);

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) w_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (r_wait == 4'd0) w_next = r_write ? ST_WR_BURST : ST_RD_BURST;
         end
         ST_RD_BURST: begin
            if (rdata_ready && w_last_beat) w_next = ST_IDLE;
         end
         ST_WR_BURST: begin
            if (wdata_valid && w_last_beat) w_next = ST_WB_ACK;
         end
         ST_WB_ACK: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_blk      <= '0;
         r_write    <= 1'b0;
         r_beat     <= '0;
         r_wait     <= '0;
         r_fill_cnt <= '0;
         r_wb_cnt   <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_blk   <= w_blk_idx;
                  r_write <= req_write;
                  r_wait  <= c_WAIT_LOAD;
                  r_beat  <= '0;
               end
            end
            ST_WAIT: begin
               if (r_wait != 4'd0) r_wait <= r_wait - 4'd1;
            end
            ST_RD_BURST: begin
               if (rdata_ready) begin
                  r_beat <= r_beat + 1'b1;
                  if (w_last_beat) r_fill_cnt <= sat_inc(r_fill_cnt);
               end
            end
            ST_WR_BURST: begin
               if (wdata_valid) r_beat <= r_beat + 1'b1;
            end
            ST_WB_ACK: begin
               r_wb_cnt <= sat_inc(r_wb_cnt);
            end
            default: begin
            end
         endcase
      end
   end

   // The beat counter only moves on a transfer, so a stalled beat keeps its address.
   assign w_ram_we   = (r_state == ST_WR_BURST) && wdata_valid;
   assign w_ram_addr = {r_blk, r_beat};

   mem_block_ram #(
      .ADDR_W (ADDR_W),
      .WORD_W (WORD_W)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_addr),
      .i_wdata (wdata),
      .o_rdata (w_ram_rdata)
   );

   assign req_ready   = (r_state == ST_IDLE);
   assign rdata_valid = (r_state == ST_RD_BURST);
   assign rdata_last  = (r_state == ST_RD_BURST) && w_last_beat;
   assign rdata       = (r_state == ST_RD_BURST) ? w_ram_rdata : '0;
   assign wdata_ready = (r_state == ST_WR_BURST);
   assign wb_done     = (r_state == ST_WB_ACK);
   assign fill_cnt    = r_fill_cnt;
   assign wb_cnt      = r_wb_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_responder.sv
//------------------------------------------------------------------------------
// Module      : tb_cache_mem_responder
// Description : Directed self-checking bench for cache_mem_responder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cache_mem_responder;

   localparam int NB  = 256;
   localparam int BS  = 16;
   localparam int WW  = 32;
   localparam int LAT = 4;
   localparam int BW  = 9;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [BW-1:0] req_block = '0;
   logic          wdata_valid = 1'b0;
   logic          wdata_ready;
   logic [WW-1:0] wdata = '0;
   logic          rdata_valid;
   logic          rdata_ready = 1'b0;
   logic [WW-1:0] rdata;
   logic          rdata_last;
   logic          wb_done;
   logic [15:0]   fill_cnt;
   logic [15:0]   wb_cnt;

   int errors = 0;
   int checks = 0;

   logic [31:0] rd_buf [16];
   int rd_n, rd_lat, rd_last_cnt, rd_last_pos, rd_stall_bad;
   bit rd_to;
   int wb_done_cnt;
   bit wb_to;

   cache_mem_responder #(
      .NUM_BLOCKS (NB),
      .BLOCK_SIZE (BS),
      .WORD_W     (WW),
      .LATENCY    (LAT),
      .BLK_W      (BW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_block   (req_block),
      .wdata_valid (wdata_valid),
      .wdata_ready (wdata_ready),
      .wdata       (wdata),
      .rdata_valid (rdata_valid),
      .rdata_ready (rdata_ready),
      .rdata       (rdata),
      .rdata_last  (rdata_last),
      .wb_done     (wb_done),
      .fill_cnt    (fill_cnt),
      .wb_cnt      (wb_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // All tasks start and end 1 time unit after a rising edge.
   task automatic send_req(input logic wr, input logic [BW-1:0] blk, output bit to);
      int n = 0;
      to = 1'b0;
      req_valid = 1'b1;
      req_write = wr;
      req_block = blk;
      while (!req_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) to = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic collect_fill(input logic [3:0] pat);
      int  cyc = 0;
      int  k = 0;
      bit  done = 1'b0;
      bit  holding = 1'b0;
      logic [31:0] held = '0;
      logic        held_last = 1'b0;
      rd_n = 0; rd_lat = -1; rd_last_cnt = 0; rd_last_pos = -1; rd_stall_bad = 0; rd_to = 1'b0;
      for (int i = 0; i < 16; i++) rd_buf[i] = 32'hDEADBEEF;
      while (!done && cyc < 300) begin
         if (rdata_valid) begin
            if (holding && (rdata !== held || rdata_last !== held_last)) rd_stall_bad++;
            rdata_ready = pat[k % 4];
            k++;
            if (rdata_ready) begin
               if (rd_n < 16) rd_buf[rd_n] = rdata;
               if (rd_n == 0) rd_lat = cyc + 1;
               if (rdata_last) begin
                  rd_last_cnt++;
                  rd_last_pos = rd_n;
                  done = 1'b1;
               end
               rd_n++;
               holding = 1'b0;
            end else begin
               held      = rdata;
               held_last = rdata_last;
               holding   = 1'b1;
            end
         end else begin
            rdata_ready = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      rdata_ready = 1'b0;
      if (!done) rd_to = 1'b1;
   endtask

   task automatic send_wb(input logic [31:0] base, input int abort_at);
      int i = 0;
      int cyc = 0;
      bit done = 1'b0;
      bit aborted = 1'b0;
      wb_done_cnt = 0;
      wb_to = 1'b0;
      while (!done && cyc < 300) begin
         if (wb_done) wb_done_cnt++;
         if (abort_at >= 0 && i == abort_at) begin
            wdata_valid = 1'b0;
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
            aborted = 1'b1;
            done = 1'b1;
         end else begin
            wdata_valid = 1'b1;
            wdata = base + 32'(i);
            if (wdata_ready) begin
               i++;
               if (i == 16) done = 1'b1;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      wdata_valid = 1'b0;
      if (!done) wb_to = 1'b1;
      if (!aborted) begin
         for (int c = 0; c < 3; c++) begin
            if (wb_done) wb_done_cnt++;
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
      checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL reset_rdata_valid: got %b want 0", rdata_valid); end
      checks++; if (rdata_last !== 1'b0) begin errors++; $display("FAIL reset_rdata_last: got %b want 0", rdata_last); end
      checks++; if (wdata_ready !== 1'b0) begin errors++; $display("FAIL reset_wdata_ready: got %b want 0", wdata_ready); end
      checks++; if (wb_done !== 1'b0) begin errors++; $display("FAIL reset_wb_done: got %b want 0", wb_done); end
      checks++; if (fill_cnt !== 16'd0) begin errors++; $display("FAIL reset_fill_cnt: got %0d want 0", fill_cnt); end
      checks++; if (wb_cnt !== 16'd0) begin errors++; $display("FAIL reset_wb_cnt: got %0d want 0", wb_cnt); end
      checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_fill_zero();
      bit to;
      int bad = 0;
      send_req(1'b0, 9'd2, to);
      collect_fill(4'b1111);
      for (int i = 0; i < 16; i++) if (rd_buf[i] !== 32'd0) bad++;
      checks++; if (to || rd_to) begin errors++; $display("FAIL fill0_timeout: req_to=%0b fill_to=%0b want 0 0", to, rd_to); end
      checks++; if (rd_n != 16) begin errors++; $display("FAIL fill0_beats: got %0d want 16", rd_n); end
      checks++; if (bad != 0) begin errors++; $display("FAIL fill0_data: %0d nonzero words, beat0=%h want 0", bad, rd_buf[0]); end
      checks++; if (rd_last_cnt != 1 || rd_last_pos != 15) begin errors++; $display("FAIL fill0_last: count=%0d pos=%0d want 1 15", rd_last_cnt, rd_last_pos); end
      checks++; if (rd_lat != LAT + 1) begin errors++; $display("FAIL fill0_latency: got %0d want %0d", rd_lat, LAT + 1); end
      checks++; if (fill_cnt !== 16'd1) begin errors++; $display("FAIL fill0_fill_cnt: got %0d want 1", fill_cnt); end
      checks++; if (wb_cnt !== 16'd0) begin errors++; $display("FAIL fill0_wb_cnt: got %0d want 0", wb_cnt); end
   endtask

   task automatic test_wb_then_fill();
      bit to;
      int bad = 0;
      send_req(1'b1, 9'd5, to);
      send_wb(32'h100, -1);
      checks++; if (to || wb_to) begin errors++; $display("FAIL wb5_timeout: req_to=%0b wb_to=%0b want 0 0", to, wb_to); end
      checks++; if (wb_done_cnt != 1) begin errors++; $display("FAIL wb5_done_pulses: got %0d want 1", wb_done_cnt); end
      checks++; if (wb_cnt !== 16'd1) begin errors++; $display("FAIL wb5_wb_cnt: got %0d want 1", wb_cnt); end
      send_req(1'b0, 9'd5, to);
      collect_fill(4'b1111);
      for (int i = 0; i < 16; i++) if (rd_buf[i] !== 32'h100 + 32'(i)) bad++;
      checks++; if (rd_n != 16) begin errors++; $display("FAIL wb5_fill_beats: got %0d want 16", rd_n); end
      checks++; if (bad != 0) begin errors++; $display("FAIL wb5_fill_data: %0d wrong words, beat15=%h want 0000010f", bad, rd_buf[15]); end
      checks++; if (fill_cnt !== 16'd2) begin errors++; $display("FAIL wb5_fill_cnt: got %0d want 2", fill_cnt); end
   endtask

   task automatic test_stall();
      bit to;
      int bad = 0;
      send_req(1'b0, 9'd5, to);
      collect_fill(4'b1001);
      for (int i = 0; i < 16; i++) if (rd_buf[i] !== 32'h100 + 32'(i)) bad++;
      checks++; if (rd_stall_bad != 0) begin errors++; $display("FAIL stall_stable: %0d unstable stall cycles want 0", rd_stall_bad); end
      checks++; if (rd_n != 16) begin errors++; $display("FAIL stall_beats: got %0d want 16", rd_n); end
      checks++; if (bad != 0) begin errors++; $display("FAIL stall_data: %0d wrong words, beat1=%h want 00000101", bad, rd_buf[1]); end
      checks++; if (rd_last_pos != 15) begin errors++; $display("FAIL stall_last_pos: got %0d want 15", rd_last_pos); end
      checks++; if (fill_cnt !== 16'd3) begin errors++; $display("FAIL stall_fill_cnt: got %0d want 3", fill_cnt); end
   endtask

   task automatic test_back_to_back();
      int a1 = -1;
      int a2 = -1;
      int acc = 0;
      int busy = 0;
      int beats = 0;
      int cyc = 0;
      bit fin = 1'b0;
      req_write = 1'b0;
      req_block = 9'd2;
      req_valid = 1'b1;
      rdata_ready = 1'b1;
      while (!fin && cyc < 200) begin
         if (acc == 1 && !req_ready) busy++;
         if (req_valid && req_ready) begin
            acc++;
            if (acc == 1) a1 = cyc;
            else if (acc == 2) a2 = cyc;
         end
         if (rdata_valid) begin
            beats++;
            if (rdata_last && acc == 2) fin = 1'b1;
         end
         @(posedge clk); #1;
         cyc++;
         if (acc >= 2) req_valid = 1'b0;
      end
      rdata_ready = 1'b0;
      req_valid = 1'b0;
      checks++; if (!fin) begin errors++; $display("FAIL b2b_finish: second fill not completed within %0d cycles", cyc); end
      checks++; if (acc != 2) begin errors++; $display("FAIL b2b_accepts: got %0d want 2", acc); end
      checks++; if (a2 - a1 != 1 + LAT + BS) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", a2 - a1, 1 + LAT + BS); end
      checks++; if (busy != LAT + BS) begin errors++; $display("FAIL b2b_ready_low: got %0d cycles want %0d", busy, LAT + BS); end
      checks++; if (beats != 32) begin errors++; $display("FAIL b2b_beats: got %0d want 32", beats); end
      checks++; if (fill_cnt !== 16'd5) begin errors++; $display("FAIL b2b_fill_cnt: got %0d want 5", fill_cnt); end
   endtask

   task automatic test_wrap();
      bit to;
      int bad = 0;
      send_req(1'b1, 9'd300, to);
      send_wb(32'hC00, -1);
      checks++; if (wb_cnt !== 16'd2) begin errors++; $display("FAIL wrap_wb_cnt: got %0d want 2", wb_cnt); end
      send_req(1'b0, 9'd44, to);
      collect_fill(4'b1111);
      for (int i = 0; i < 16; i++) if (rd_buf[i] !== 32'hC00 + 32'(i)) bad++;
      checks++; if (bad != 0 || rd_n != 16) begin errors++; $display("FAIL wrap_data: %0d wrong words of %0d, beat0=%h want 00000c00", bad, rd_n, rd_buf[0]); end
      checks++; if (fill_cnt !== 16'd6) begin errors++; $display("FAIL wrap_fill_cnt: got %0d want 6", fill_cnt); end
   endtask

   task automatic test_reset_mid_wb();
      bit to;
      int bad = 0;
      logic [31:0] exp;
      send_req(1'b1, 9'd9, to);
      send_wb(32'hA00, -1);
      checks++; if (wb_cnt !== 16'd3) begin errors++; $display("FAIL abort_pre_wb_cnt: got %0d want 3", wb_cnt); end
      send_req(1'b1, 9'd9, to);
      send_wb(32'hB00, 7);
      checks++; if (wb_cnt !== 16'd0 || fill_cnt !== 16'd0) begin errors++; $display("FAIL abort_counters: wb=%0d fill=%0d want 0 0", wb_cnt, fill_cnt); end
      checks++; if (req_ready !== 1'b1 || wdata_ready !== 1'b0) begin errors++; $display("FAIL abort_idle: req_ready=%b wdata_ready=%b want 1 0", req_ready, wdata_ready); end
      send_req(1'b0, 9'd9, to);
      collect_fill(4'b1111);
      for (int i = 0; i < 16; i++) begin
         exp = (i < 7) ? 32'hB00 + 32'(i) : 32'hA00 + 32'(i);
         if (rd_buf[i] !== exp) bad++;
      end
      checks++; if (bad != 0 || rd_n != 16) begin errors++; $display("FAIL abort_data: %0d wrong words of %0d, beat6=%h beat7=%h want 00000b06 00000a07", bad, rd_n, rd_buf[6], rd_buf[7]); end
      checks++; if (wb_cnt !== 16'd0 || fill_cnt !== 16'd1) begin errors++; $display("FAIL abort_post_counts: wb=%0d fill=%0d want 0 1", wb_cnt, fill_cnt); end
   endtask

   initial begin
      test_reset();
      test_fill_zero();
      test_wb_then_fill();
      test_stall();
      test_back_to_back();
      test_wrap();
      test_reset_mid_wb();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
